// File: rtl/jtag_tap_ir.sv
// IEEE 1149.1 TAP controller with a 2-bit instruction register.
// Optional macro TAP_TDO_NEGEDGE_EN retimes TDO/bs_en onto the falling TCLK edge.
module jtag_tap_ir (
   input  logic       TCLK,
   input  logic       TRST,
   input  logic       TMS,
   input  logic       TDI,
   output logic       TDO,
   output logic [1:0] inst,
   output logic [3:0] state,
   output logic       clockdr,
   output logic       shiftdr,
   output logic       updatedr,
   output logic       clockir,
   output logic       shiftir,
   output logic       updateir,
   output logic       select,
   output logic       bs_en
);

   typedef enum logic [3:0] {
      TLR     = 4'hF,
      RTI     = 4'hC,
      SELDR   = 4'h7,
      CAPDR   = 4'h6,
      SHDR    = 4'h2,
      EX1DR   = 4'h1,
      PAUSEDR = 4'h3,
      EX2DR   = 4'h0,
      UPDDR   = 4'h5,
      SELIR   = 4'h4,
      CAPIR   = 4'hE,
      SHIR    = 4'hA,
      EX1IR   = 4'h9,
      PAUSEIR = 4'hB,
      EX2IR   = 4'h8,
      UPDIR   = 4'hD
   } tap_state_t;

   tap_state_t r_state;
   tap_state_t w_next;
   logic [1:0] r_sr;
   logic [1:0] r_inst;
   logic       w_tdo;
   logic       w_bs_en;

   always_ff @(posedge TCLK or posedge TRST) begin
      if (TRST) r_state <= TLR;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      clockdr  = 1'b0;
      shiftdr  = 1'b0;
      updatedr = 1'b0;
      clockir  = 1'b0;
      shiftir  = 1'b0;
      updateir = 1'b0;
      select   = 1'b0;
      case (r_state)
         TLR:     w_next = TMS ? TLR   : RTI;
         RTI:     w_next = TMS ? SELDR : RTI;
         SELDR:   w_next = TMS ? SELIR : CAPDR;
         CAPDR:   w_next = TMS ? EX1DR : SHDR;
         SHDR:    w_next = TMS ? EX1DR : SHDR;
         EX1DR:   w_next = TMS ? UPDDR : PAUSEDR;
         PAUSEDR: w_next = TMS ? EX2DR : PAUSEDR;
         EX2DR:   w_next = TMS ? UPDDR : SHDR;
         UPDDR:   w_next = TMS ? SELDR : RTI;
         SELIR:   w_next = TMS ? TLR   : CAPIR;
         CAPIR:   w_next = TMS ? EX1IR : SHIR;
         SHIR:    w_next = TMS ? EX1IR : SHIR;
         EX1IR:   w_next = TMS ? UPDIR : PAUSEIR;
         PAUSEIR: w_next = TMS ? EX2IR : PAUSEIR;
         EX2IR:   w_next = TMS ? UPDIR : SHIR;
         UPDIR:   w_next = TMS ? SELDR : RTI;
         default: w_next = TLR;
      endcase
      clockdr  = (r_state == CAPDR) || (r_state == SHDR);
      shiftdr  = (r_state == SHDR);
      updatedr = (r_state == UPDDR);
      clockir  = (r_state == CAPIR) || (r_state == SHIR);
      shiftir  = (r_state == SHIR);
      updateir = (r_state == UPDIR);
      select   = (r_state == SELIR) || (r_state == CAPIR) || (r_state == SHIR) ||
                 (r_state == EX1IR) || (r_state == PAUSEIR) || (r_state == EX2IR) ||
                 (r_state == UPDIR);
   end

   // Instruction path: capture/shift only touch sr; inst is loaded from sr in UpdIR.
   always_ff @(posedge TCLK or posedge TRST) begin
      if (TRST) begin
         r_sr   <= 2'b01;
         r_inst <= 2'b11;
      end else begin
         if (r_state == CAPIR)     r_sr <= 2'b01;
         else if (r_state == SHIR) r_sr <= {TDI, r_sr[1]};
         if (r_state == UPDIR)     r_inst <= r_sr;
         else if (r_state == TLR)  r_inst <= 2'b11;
      end
   end

   assign w_tdo   = (r_state == SHIR) ? r_sr[0] : 1'b0;
   assign w_bs_en = (r_state == SHDR) || (r_state == SHIR);
   assign inst    = r_inst;
   assign state   = r_state;

`ifdef TAP_TDO_NEGEDGE_EN
   logic r_tdo;
   logic r_bs_en;

   always_ff @(negedge TCLK or posedge TRST) begin
      if (TRST) begin
         r_tdo   <= 1'b0;
         r_bs_en <= 1'b0;
      end else begin
         r_tdo   <= w_tdo;
         r_bs_en <= w_bs_en;
      end
   end

   assign TDO   = r_tdo;
   assign bs_en = r_bs_en;
`else
   assign TDO   = w_tdo;
   assign bs_en = w_bs_en;
`endif

endmodule

// File: tb/tb_jtag_tap_ir.sv
// Scoreboard bench for jtag_tap_ir: stimulus queues expected TAP outputs, a
// falling-edge monitor pops and compares them.
module tb_jtag_tap_ir;

   logic       TCLK = 1'b0;
   logic       TRST = 1'b1;
   logic       TMS  = 1'b1;
   logic       TDI  = 1'b0;
   logic       TDO;
   logic [1:0] inst;
   logic [3:0] state;
   logic       clockdr, shiftdr, updatedr, clockir, shiftir, updateir, select, bs_en;

   jtag_tap_ir dut (
      .TCLK     (TCLK),
      .TRST     (TRST),
      .TMS      (TMS),
      .TDI      (TDI),
      .TDO      (TDO),
      .inst     (inst),
      .state    (state),
      .clockdr  (clockdr),
      .shiftdr  (shiftdr),
      .updatedr (updatedr),
      .clockir  (clockir),
      .shiftir  (shiftir),
      .updateir (updateir),
      .select   (select),
      .bs_en    (bs_en)
   );

   always #5 TCLK = ~TCLK;

   typedef struct {
      string      nm;
      logic [3:0] st;
      logic [1:0] in;
      logic       tdo;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   logic stim_done = 1'b0;

   // {clockdr,shiftdr,updatedr,clockir,shiftir,updateir,select,bs_en} per state
   function automatic logic [7:0] strobes_for(input logic [3:0] st);
      case (st)
         4'h6:    return 8'b1000_0000;
         4'h2:    return 8'b1100_0001;
         4'h5:    return 8'b0010_0000;
         4'h4:    return 8'b0000_0010;
         4'hE:    return 8'b0001_0010;
         4'hA:    return 8'b0001_1011;
         4'h9:    return 8'b0000_0010;
         4'hB:    return 8'b0000_0010;
         4'h8:    return 8'b0000_0010;
         4'hD:    return 8'b0000_0110;
         default: return 8'b0000_0000;
      endcase
   endfunction

   task automatic step(input logic tms, input logic tdi, input logic [3:0] st,
                       input logic [1:0] in, input logic tdo, input string nm);
      exp_t e;
      TMS = tms;
      TDI = tdi;
      @(posedge TCLK);
      #1;
      e.nm = nm; e.st = st; e.in = in; e.tdo = tdo;
      q.push_back(e);
   endtask

   task automatic reset_pulse(input string nm);
      exp_t e;
      @(posedge TCLK);
      #1;
      TRST = 1'b1;
      e.nm = nm; e.st = 4'hF; e.in = 2'b11; e.tdo = 1'b0;
      q.push_back(e);
      @(negedge TCLK);
      #2;
      TRST = 1'b0;
   endtask

   initial begin : monitor
      exp_t       e;
      logic [7:0] act_s;
      forever begin
         @(negedge TCLK);
         #1;
         if (q.size() > 0) begin
            e     = q.pop_front();
            act_s = {clockdr, shiftdr, updatedr, clockir, shiftir, updateir, select, bs_en};
            n_vec++;
            if (state !== e.st || inst !== e.in || TDO !== e.tdo || act_s !== strobes_for(e.st)) begin
               n_bad++;
               $display("FAIL %s: got state=%h inst=%b tdo=%b strobes=%b, want state=%h inst=%b tdo=%b strobes=%b",
                        e.nm, state, inst, TDO, act_s, e.st, e.in, e.tdo, strobes_for(e.st));
            end
         end
      end
   end

   initial begin : stim
      // Reset held, then released in TLR
      step(1, 0, 4'hF, 2'b11, 0, "rst_hold0");
      step(1, 0, 4'hF, 2'b11, 0, "rst_hold1");
      TRST = 1'b0;
      step(1, 0, 4'hF, 2'b11, 0, "tlr_stay0");
      step(1, 0, 4'hF, 2'b11, 0, "tlr_stay1");
      step(1, 0, 4'hF, 2'b11, 0, "tlr_stay2");
      step(0, 0, 4'hC, 2'b11, 0, "to_rti");

      // Direct IR load -> inst=10
      step(1, 0, 4'h7, 2'b11, 0, "ld_seldr");
      step(1, 0, 4'h4, 2'b11, 0, "ld_selir");
      step(0, 0, 4'hE, 2'b11, 0, "ld_capir");
      step(0, 0, 4'hA, 2'b11, 1, "ld_shir_tdo1");
      step(0, 0, 4'hA, 2'b11, 0, "ld_shir_tdo0");
      step(1, 1, 4'h9, 2'b11, 0, "ld_ex1ir");
      step(1, 0, 4'hD, 2'b11, 0, "ld_updir");
      step(0, 0, 4'hC, 2'b10, 0, "ld_rti_inst10");

      // Pause path -> inst=01
      step(1, 0, 4'h7, 2'b10, 0, "pp_seldr");
      step(1, 0, 4'h4, 2'b10, 0, "pp_selir");
      step(0, 0, 4'hE, 2'b10, 0, "pp_capir");
      step(0, 0, 4'hA, 2'b10, 1, "pp_shir");
      step(0, 1, 4'hA, 2'b10, 0, "pp_shir2");
      step(1, 1, 4'h9, 2'b10, 0, "pp_ex1ir");
      step(0, 0, 4'hB, 2'b10, 0, "pp_pauseir");
      step(1, 0, 4'h8, 2'b10, 0, "pp_ex2ir");
      step(0, 0, 4'hA, 2'b10, 1, "pp_shir_resume");
      step(1, 0, 4'h9, 2'b10, 0, "pp_ex1ir2");
      step(1, 0, 4'hD, 2'b10, 0, "pp_updir");
      step(0, 0, 4'hC, 2'b01, 0, "pp_rti_inst01");

      // DR column, inst untouched
      step(1, 0, 4'h7, 2'b01, 0, "dr_seldr");
      step(0, 0, 4'h6, 2'b01, 0, "dr_capdr");
      step(0, 1, 4'h2, 2'b01, 0, "dr_shdr");
      step(1, 0, 4'h1, 2'b01, 0, "dr_ex1dr");
      step(1, 0, 4'h5, 2'b01, 0, "dr_upddr");
      step(0, 0, 4'hC, 2'b01, 0, "dr_rti");

      // Async reset mid-shift, then TLR hold and a capture-only IR update
      step(1, 0, 4'h7, 2'b01, 0, "ar_seldr");
      step(1, 0, 4'h4, 2'b01, 0, "ar_selir");
      step(0, 0, 4'hE, 2'b01, 0, "ar_capir");
      step(0, 0, 4'hA, 2'b01, 1, "ar_shir");
      step(0, 0, 4'hA, 2'b01, 0, "ar_shir2");
      TMS = 1'b0;
      TDI = 1'b1;
      reset_pulse("ar_async_reset");
      for (int i = 0; i < 5; i++) step(1, 0, 4'hF, 2'b11, 0, "ar_tlr_hold");
      step(0, 0, 4'hC, 2'b11, 0, "ar_rti");
      step(1, 0, 4'h7, 2'b11, 0, "ar_seldr2");
      step(1, 0, 4'h4, 2'b11, 0, "ar_selir2");
      step(0, 0, 4'hE, 2'b11, 0, "ar_capir2");
      step(1, 0, 4'h9, 2'b11, 0, "ar_ex1ir2");
      step(1, 0, 4'h0 + 4'hD, 2'b11, 0, "ar_updir2");
      step(0, 0, 4'hC, 2'b01, 0, "ar_rti_inst01");
      stim_done = 1'b1;
   end

   initial begin : finisher
      int guard;
      guard = 0;
      while (!stim_done && guard < 2000) begin
         @(posedge TCLK);
         guard++;
      end
      if (!stim_done) begin
         n_bad++;
         $display("FAIL stim_timeout: got stimulus unfinished, want finished within 2000 cycles");
      end
      guard = 0;
      while (q.size() > 0 && guard < 10) begin
         @(posedge TCLK);
         guard++;
      end
      @(negedge TCLK);
      #3;
      if (q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
